// File: rtl/htf_pkg.sv
// Shared definitions for the host-to-fabric pipe-in block: FSM state
// encoding, default parameter values and the occupancy width helper.
// Optional feature macro used by the top: HTF_REARM_EN.
package htf_pkg;

  localparam int unsigned HTF_DATA_W_DEF        = 16;
  localparam int unsigned HTF_DEPTH_DEF         = 256;
  localparam int unsigned HTF_BURST_LEN_DEF     = 256;
  localparam int unsigned HTF_SETTLE_CYCLES_DEF = 100;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } htf_state_e;

  // Occupancy must represent 0..DEPTH inclusive.
  function automatic int unsigned htf_level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/htf_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Read data is the word at the
// head pointer, combinationally. Reset clears pointers only; memory keeps
// stale contents, which are unreachable once the pointers are cleared.
module htf_sync_fifo
  import htf_pkg::*;
#(
  parameter int unsigned DATA_W = HTF_DATA_W_DEF,
  parameter int unsigned DEPTH  = HTF_DEPTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             rd_data_o,
  output logic [htf_level_w(DEPTH)-1:0] level_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = htf_level_w(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_cnt_q, wr_cnt_d;
  logic [AW:0]       rd_cnt_q, rd_cnt_d;
  logic              do_push, do_pop;

  assign level_o   = LW'(wr_cnt_q - rd_cnt_q);
  assign full_o    = (level_o == LW'(DEPTH));
  assign empty_o   = (level_o == '0);
  assign rd_data_o = mem_q[rd_cnt_q[AW-1:0]];

  // Guard against overflow/underflow regardless of caller behaviour.
  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (do_push) wr_cnt_d = wr_cnt_q + 1'b1;
    if (do_pop)  rd_cnt_d = rd_cnt_q + 1'b1;
  end

  // Storage write; not reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_cnt_q[AW-1:0]] <= wr_data_i;
  end

  // Read/write counters; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

endmodule

// File: rtl/host_to_fabric_fifo.sv
// Host-to-fabric pipe-in: settle, accept one host burst, drain it to the
// fabric over valid/ready, then signal done.
// HTF_REARM_EN: when defined, DONE holds for SETTLE_CYCLES then re-arms
// into LOAD for another burst; otherwise DONE is terminal until reset.
module host_to_fabric_fifo
  import htf_pkg::*;
#(
  parameter int unsigned DATA_W        = HTF_DATA_W_DEF,
  parameter int unsigned DEPTH         = HTF_DEPTH_DEF,
  parameter int unsigned BURST_LEN     = HTF_BURST_LEN_DEF,
  parameter int unsigned SETTLE_CYCLES = HTF_SETTLE_CYCLES_DEF
) (
  input  logic                          write_clk,
  input  logic                          reset,
  input  logic                          ep_write,
  input  logic [DATA_W-1:0]             ep_data,
  output logic                          ep_ready,
  output logic                          fab_valid,
  output logic [DATA_W-1:0]             fab_data,
  input  logic                          fab_ready,
  output logic [htf_level_w(DEPTH)-1:0] level,
  output logic                          done,
  output logic                          drop_err
);

  localparam int unsigned LW = htf_level_w(DEPTH);
  localparam int unsigned CW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BW = $clog2(BURST_LEN + 1);

  htf_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              drop_q, drop_d;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rd_data;

  htf_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i     (write_clk),
    .rst_i     (reset),
    .push_i    (push),
    .wr_data_i (ep_data),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // Output decodes depend on state and occupancy only.
  always_comb begin
    ep_ready  = (state_q == ST_LOAD) && !fifo_full;
    fab_valid = (state_q == ST_DRAIN) && !fifo_empty;
    done      = (state_q == ST_DONE);
    fab_data  = fab_valid ? fifo_rd_data : '0;
    push      = ep_write && ep_ready;
    pop       = fab_valid && fab_ready;
    drop_err  = drop_q;
  end

  // Next-state logic for sequencing, settle counter and burst counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    drop_d  = drop_q | (ep_write & ~ep_ready);
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_LOAD: begin
        if (push) begin
          if (burst_q == BW'(BURST_LEN - 1)) begin
            burst_d = '0;
            state_d = ST_DRAIN;
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (level == LW'(1))) state_d = ST_DONE;
      end
      ST_DONE: begin
`ifdef HTF_REARM_EN
        // Settle counter is reused to time the done hold before re-arming.
        if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`else
        state_d = ST_DONE;
`endif
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  // State, counters and sticky drop flag.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      burst_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_host_to_fabric_fifo.sv
// Directed bench for host_to_fabric_fifo with DEPTH=4, BURST_LEN=4,
// SETTLE_CYCLES=100. Build with HTF_REARM_EN defined to exercise re-arm.
module tb_host_to_fabric_fifo;

  localparam int unsigned DW = 16;
  localparam int unsigned DP = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned SC = 100;
  localparam int unsigned LW = 3;

  logic          write_clk = 1'b0;
  logic          reset     = 1'b1;
  logic          ep_write  = 1'b0;
  logic [DW-1:0] ep_data   = '0;
  logic          ep_ready;
  logic          fab_valid;
  logic [DW-1:0] fab_data;
  logic          fab_ready = 1'b0;
  logic [LW-1:0] level;
  logic          done;
  logic          drop_err;

  int total = 0;
  int bad   = 0;

  host_to_fabric_fifo #(
    .DATA_W        (DW),
    .DEPTH         (DP),
    .BURST_LEN     (BL),
    .SETTLE_CYCLES (SC)
  ) dut (
    .write_clk (write_clk),
    .reset     (reset),
    .ep_write  (ep_write),
    .ep_data   (ep_data),
    .ep_ready  (ep_ready),
    .fab_valid (fab_valid),
    .fab_data  (fab_data),
    .fab_ready (fab_ready),
    .level     (level),
    .done      (done),
    .drop_err  (drop_err)
  );

  always #5 write_clk = ~write_clk;

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic do_reset();
    ep_write  = 1'b0;
    fab_ready = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_settle();
    for (int unsigned i = 0; i < SC; i++) tick();
  endtask

  task automatic load_burst(input logic [DW-1:0] base);
    for (int unsigned i = 0; i < BL; i++) begin
      ep_write = 1'b1;
      ep_data  = base + DW'(i);
      tick();
    end
    ep_write = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({ep_ready, fab_valid, fab_data, level, done, drop_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b val=%b data=%h lvl=%0d done=%b drop=%b want all 0",
               ep_ready, fab_valid, fab_data, level, done, drop_err);
    end
    for (int unsigned e = 1; e < SC; e++) begin
      tick();
      if (ep_ready !== 1'b0) begin
        total++; bad++;
        $display("FAIL settle_ready edge %0d got %b want 0", e, ep_ready);
      end
    end
    total++;
    if (ep_ready !== 1'b0) begin
      bad++;
      $display("FAIL settle_ready_edge99 got %b want 0", ep_ready);
    end
    tick();
    total++;
    if (ep_ready !== 1'b1) begin
      bad++;
      $display("FAIL settle_ready_edge100 got %b want 1", ep_ready);
    end
    total++;
    if ({fab_valid, fab_data, level, done, drop_err} !== '0) begin
      bad++;
      $display("FAIL settle_others got val=%b data=%h lvl=%0d done=%b drop=%b want 0",
               fab_valid, fab_data, level, done, drop_err);
    end
  endtask

  task automatic test_burst();
    logic [DW-1:0] exp_d;
    do_reset();
    wait_settle();
    for (int unsigned i = 0; i < BL; i++) begin
      ep_write = 1'b1;
      ep_data  = DW'(i + 1);
      tick();
      total++;
      if (level !== LW'(i + 1)) begin
        bad++;
        $display("FAIL load_level word %0d got %0d want %0d", i + 1, level, i + 1);
      end
    end
    ep_write = 1'b0;
    total++;
    if (fab_valid !== 1'b1 || ep_ready !== 1'b0 || level !== LW'(4)) begin
      bad++;
      $display("FAIL drain_start got val=%b rdy=%b lvl=%0d want 1 0 4", fab_valid, ep_ready, level);
    end
    fab_ready = 1'b1;
    for (int unsigned i = 0; i < BL; i++) begin
      exp_d = DW'(i + 1);
      total++;
      if (fab_valid !== 1'b1 || fab_data !== exp_d) begin
        bad++;
        $display("FAIL drain_word %0d got val=%b data=%h want 1 %h", i, fab_valid, fab_data, exp_d);
      end
      tick();
    end
    fab_ready = 1'b0;
    total++;
    if (done !== 1'b1 || fab_valid !== 1'b0 || fab_data !== '0 || level !== '0) begin
      bad++;
      $display("FAIL burst_done got done=%b val=%b data=%h lvl=%0d want 1 0 0 0",
               done, fab_valid, fab_data, level);
    end
    total++;
    if (drop_err !== 1'b0) begin
      bad++;
      $display("FAIL burst_no_drop got %b want 0", drop_err);
    end
`ifdef HTF_REARM_EN
    for (int unsigned i = 1; i < SC; i++) tick();
    total++;
    if (done !== 1'b1 || ep_ready !== 1'b0) begin
      bad++;
      $display("FAIL rearm_hold got done=%b rdy=%b want 1 0", done, ep_ready);
    end
    tick();
    total++;
    if (done !== 1'b0 || ep_ready !== 1'b1) begin
      bad++;
      $display("FAIL rearm_open got done=%b rdy=%b want 0 1", done, ep_ready);
    end
    load_burst(16'h0B00);
    fab_ready = 1'b1;
    for (int unsigned i = 0; i < BL; i++) begin
      exp_d = 16'h0B00 + DW'(i);
      total++;
      if (fab_valid !== 1'b1 || fab_data !== exp_d) begin
        bad++;
        $display("FAIL wrap_word %0d got val=%b data=%h want 1 %h", i, fab_valid, fab_data, exp_d);
      end
      tick();
    end
    fab_ready = 1'b0;
    total++;
    if (done !== 1'b1 || level !== '0) begin
      bad++;
      $display("FAIL wrap_done got done=%b lvl=%0d want 1 0", done, level);
    end
`else
    for (int unsigned i = 0; i < SC + 20; i++) tick();
    total++;
    if (done !== 1'b1 || ep_ready !== 1'b0 || fab_valid !== 1'b0) begin
      bad++;
      $display("FAIL oneshot_terminal got done=%b rdy=%b val=%b want 1 0 0", done, ep_ready, fab_valid);
    end
`endif
  endtask

  task automatic test_drop();
    do_reset();
    ep_write = 1'b1;
    ep_data  = 16'hDEAD;
    tick();
    ep_write = 1'b0;
    total++;
    if (drop_err !== 1'b1 || level !== '0) begin
      bad++;
      $display("FAIL drop_settle got drop=%b lvl=%0d want 1 0", drop_err, level);
    end
    for (int unsigned i = 1; i < SC; i++) tick();
    load_burst(16'h00C0);
    ep_write = 1'b1;
    ep_data  = 16'hBEEF;
    tick();
    ep_write = 1'b0;
    total++;
    if (drop_err !== 1'b1 || level !== LW'(4) || fab_data !== 16'h00C0) begin
      bad++;
      $display("FAIL drop_drain got drop=%b lvl=%0d data=%h want 1 4 00c0", drop_err, level, fab_data);
    end
    fab_ready = 1'b1;
    for (int unsigned i = 0; i < BL; i++) begin
      total++;
      if (fab_data !== 16'h00C0 + DW'(i)) begin
        bad++;
        $display("FAIL drop_data %0d got %h want %h", i, fab_data, 16'h00C0 + DW'(i));
      end
      tick();
    end
    fab_ready = 1'b0;
    total++;
    if (drop_err !== 1'b1 || done !== 1'b1) begin
      bad++;
      $display("FAIL drop_sticky got drop=%b done=%b want 1 1", drop_err, done);
    end
  endtask

  task automatic test_toggle();
    logic          rdy_pat [4];
    logic [DW-1:0] exp_d   [4];
    logic [LW-1:0] exp_l   [4];
    rdy_pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_d   = '{16'h00A2, 16'h00A2, 16'h00A3, 16'h00A3};
    exp_l   = '{3'd3, 3'd3, 3'd2, 3'd2};
    do_reset();
    wait_settle();
    load_burst(16'h00A1);
    for (int unsigned i = 0; i < 4; i++) begin
      fab_ready = rdy_pat[i];
      tick();
      total++;
      if (fab_data !== exp_d[i] || level !== exp_l[i] || fab_valid !== 1'b1) begin
        bad++;
        $display("FAIL toggle step %0d got data=%h lvl=%0d val=%b want %h %0d 1",
                 i, fab_data, level, fab_valid, exp_d[i], exp_l[i]);
      end
    end
    fab_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    ep_write = 1'b1;
    tick();
    ep_write = 1'b0;
    for (int unsigned i = 1; i < SC; i++) tick();
    load_burst(16'h0011);
    fab_ready = 1'b1;
    tick();
    fab_ready = 1'b0;
    total++;
    if (level !== LW'(3) || fab_valid !== 1'b1 || drop_err !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset got lvl=%0d val=%b drop=%b want 3 1 1", level, fab_valid, drop_err);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (fab_valid !== 1'b0 || level !== '0 || fab_data !== '0 || drop_err !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL async_reset got val=%b lvl=%0d data=%h drop=%b done=%b want 0",
               fab_valid, level, fab_data, drop_err, done);
    end
    tick();
    reset = 1'b0;
    for (int unsigned i = 1; i < SC; i++) tick();
    total++;
    if (ep_ready !== 1'b0) begin
      bad++;
      $display("FAIL restart_settle got %b want 0", ep_ready);
    end
    tick();
    total++;
    if (ep_ready !== 1'b1 || level !== '0) begin
      bad++;
      $display("FAIL restart_load got rdy=%b lvl=%0d want 1 0", ep_ready, level);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_drop();
    test_toggle();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
